wb_sram_slave: RTL

WB_SRAM_SLAVE -- requirements
Module: wb_sram_slave

---
 rtl/wb_pkg.sv | 26 ++
 rtl/wb_burst_addr.sv | 27 ++
 rtl/wb_sram_slave.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: cycle-type / burst-type codes and the SRAM slave FSM encoding.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_GAP  = 2'd3
  } wb_state_t;

  // Beats that keep the burst going; anything else ends the cycle.
  function automatic logic cti_continues(input logic [2:0] cti);
    return (cti == CTI_INCR) || (cti == CTI_CONST);
  endfunction

endpackage

// File: rtl/wb_burst_addr.sv
// Combinational burst address advance: linear or wrap-4/8/16, held for constant-address bursts.
module wb_burst_addr
  import wb_pkg::*;
#(
  parameter int ADDRESS = 21
) (
  input  logic [ADDRESS-1:0] addr,
  input  logic [1:0]         bte,
  input  logic [2:0]         cti,
  output logic [ADDRESS-1:0] nxt_addr
);

  localparam logic [ADDRESS-1:0] ONE = {{(ADDRESS-1){1'b0}}, 1'b1};

  always_comb begin
    nxt_addr = addr;
    if (cti != CTI_CONST) begin
      case (bte)
        BTE_LINEAR: nxt_addr = addr + ONE;
        BTE_WRAP4:  nxt_addr[1:0] = addr[1:0] + 2'd1;
        BTE_WRAP8:  nxt_addr[2:0] = addr[2:0] + 3'd1;
        default:    nxt_addr[3:0] = addr[3:0] + 4'd1;
      endcase
    end
  end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone SRAM slave with wait states and registered burst acks.
// Define WB_SRAM_SLAVE_ERR_EN to answer out-of-range beats with err_o instead of aliasing.
module wb_sram_slave
  import wb_pkg::*;
#(
  parameter int ADDRESS    = 21,
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT       = 0
) (
  input  logic               wb_clk,
  input  logic               reset,
  input  logic               cyc_i,
  input  logic               stb_i,
  input  logic               we_i,
  input  logic [2:0]         cti_i,
  input  logic [1:0]         bte_i,
  input  logic [ADDRESS-1:0] adr_i,
  input  logic [3:0]         sel_i,
  input  logic [31:0]        dat_i,
  output logic               ack_o,
  output logic               rty_o,
  output logic               err_o,
  output logic [3:0]         sel_o,
  output logic [31:0]        dat_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  wb_state_t              state, state_nxt;
  logic [ADDRESS-1:0]     cnt, cnt_nxt, cnt_adv;
  logic [1:0]             wait_cnt, wait_nxt;
  logic                   resp_nxt, oor_nxt, beat, wr_en;
  logic                   ack_r, err_r;
  logic [3:0]             sel_r;
  logic [31:0]            dat_r, wr_word, rd_word;
  logic [DEPTH_LOG2-1:0]  idx, idx_nxt;
  logic [31:0]            mem [DEPTH];

  assign idx     = cnt[DEPTH_LOG2-1:0];
  assign idx_nxt = cnt_nxt[DEPTH_LOG2-1:0];

  wb_burst_addr #(.ADDRESS(ADDRESS)) u_burst_addr (
    .addr     (cnt),
    .bte      (bte_i),
    .cti      (cti_i),
    .nxt_addr (cnt_adv)
  );

  // A beat retires on the edge where the registered response meets a live strobe.
  assign beat  = (state == S_ACK) & cyc_i & stb_i & (ack_r | err_r);
  assign wr_en = beat & we_i & ack_r & ~reset;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wait_nxt  = wait_cnt;
    resp_nxt  = 1'b0;
    if (!cyc_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (stb_i) begin
          cnt_nxt = adr_i;
          if (WAIT == 0) begin
            state_nxt = S_ACK;
            resp_nxt  = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            wait_nxt  = 2'(WAIT - 1);
          end
        end
        S_WAIT: if (wait_cnt == 2'd0) begin
          state_nxt = S_ACK;
          resp_nxt  = 1'b1;
        end else begin
          wait_nxt = wait_cnt - 2'd1;
        end
        S_ACK: begin
          // Stall drops the response for the cycle; the returning strobe re-arms it.
          if (!stb_i)                resp_nxt = 1'b0;
          else if (!(ack_r | err_r)) resp_nxt = 1'b1;
          else if (cti_continues(cti_i)) begin
            cnt_nxt  = cnt_adv;
            resp_nxt = 1'b1;
          end else begin
            state_nxt = S_GAP;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

`ifdef WB_SRAM_SLAVE_ERR_EN
  assign oor_nxt = |(cnt_nxt >> DEPTH_LOG2);
`else
  assign oor_nxt = 1'b0;
`endif

  always_comb begin
    wr_word = mem[idx];
    for (int l = 0; l < 4; l++)
      if (sel_i[l]) wr_word[8*l +: 8] = dat_i[8*l +: 8];
  end

  // Constant-address bursts re-read the word being written on the same edge.
  always_comb begin
    rd_word = mem[idx_nxt];
    if (wr_en && (idx_nxt == idx)) rd_word = wr_word;
  end

  always_ff @(posedge wb_clk) begin
    if (wr_en) mem[idx] <= wr_word;
  end

  always_ff @(posedge wb_clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      wait_cnt <= '0;
      ack_r    <= 1'b0;
      err_r    <= 1'b0;
      sel_r    <= '0;
      dat_r    <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wait_cnt <= wait_nxt;
      ack_r    <= resp_nxt & ~oor_nxt;
      err_r    <= resp_nxt & oor_nxt;
      sel_r    <= (resp_nxt & ~oor_nxt) ? 4'hF : 4'h0;
      dat_r    <= (resp_nxt & ~oor_nxt) ? rd_word : 32'h0;
    end
  end

  assign ack_o = ack_r;
  assign err_o = err_r;
  assign rty_o = 1'b0;
  assign sel_o = sel_r;
  assign dat_o = dat_r;

endmodule
